// File: rtl/vctrl_pkg.sv
// Shared types, opcode constants and the opcode decoder for the vector control sequencer.
// VEC_MEM_EN enables decoding of the vector load/store opcodes as multi-beat vector ops.
package vctrl_pkg;

   typedef struct packed {
      logic       reg_dst;
      logic [1:0] alu_op;
      logic       alu_src;
      logic       reg_write;
      logic       mem_rd;
      logic       mem_wr;
      logic       vmem_wr;
      logic       branch;
      logic       mem_to_reg;
      logic       imm_sel;
      logic       vec;
   } ctrl_t;

   localparam logic [6:0] OP_ADDI = 7'b0010011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_LD   = 7'b0000011;
   localparam logic [6:0] OP_ST   = 7'b0100011;
   localparam logic [6:0] OP_VEC  = 7'b1010111;
   localparam logic [6:0] OP_VLD  = 7'b0000111;
   localparam logic [6:0] OP_VST  = 7'b0100111;

   function automatic ctrl_t decode_op(input logic [6:0] op);
      ctrl_t c;
      c = '0;
      case (op)
         OP_R: begin
            c.alu_op    = 2'b10;
            c.reg_write = 1'b1;
            c.reg_dst   = 1'b1;
         end
         OP_BR: begin
            c.alu_op  = 2'b01;
            c.alu_src = 1'b1;
            c.branch  = 1'b1;
         end
         OP_LD: begin
            c.alu_src    = 1'b1;
            c.mem_rd     = 1'b1;
            c.mem_to_reg = 1'b1;
            c.reg_write  = 1'b1;
         end
         OP_ST: begin
            c.alu_src = 1'b1;
            c.mem_wr  = 1'b1;
            c.imm_sel = 1'b1;
         end
         OP_VEC: begin
            c.reg_write = 1'b1;
            c.reg_dst   = 1'b1;
            c.vec       = 1'b1;
         end
`ifdef VEC_MEM_EN
         OP_VLD: begin
            c.alu_src    = 1'b1;
            c.mem_rd     = 1'b1;
            c.mem_to_reg = 1'b1;
            c.reg_write  = 1'b1;
            c.vec        = 1'b1;
         end
         OP_VST: begin
            c.alu_src = 1'b1;
            c.vmem_wr = 1'b1;
            c.imm_sel = 1'b1;
            c.vec     = 1'b1;
         end
`endif
         default: begin
            c.alu_op    = 2'b11;
            c.alu_src   = 1'b1;
            c.reg_write = 1'b1;
            c.reg_dst   = 1'b1;
         end
      endcase
      return c;
   endfunction

endpackage

// File: rtl/vctrl_lane_mask_gen.sv
// Combinational lane mask and last-beat flag for a given beat index and vector length.
module vctrl_lane_mask_gen #(
   parameter int LANES  = 4,
   parameter int VL_W   = 5,
   parameter int BEAT_W = 2
) (
   input  logic [BEAT_W-1:0] beat_i,
   input  logic [VL_W-1:0]   vl_i,
   output logic [LANES-1:0]  lane_mask_o,
   output logic              last_o
);

   always_comb begin
      lane_mask_o = '0;
      for (int i = 0; i < LANES; i++) begin
         lane_mask_o[i] = ((int'(beat_i) * LANES) + i) < int'(vl_i);
      end
      // vl==0 yields last on beat 0, giving the single empty beat
      last_o = ((int'(beat_i) + 1) * LANES) >= int'(vl_i);
   end

endmodule

// File: rtl/vector_ctrl_sequencer.sv
// Decodes opcodes to a control word and issues it as one or more registered beats.
// VEC_MEM_EN enables vector load/store opcodes; otherwise ctrl_o.vmem_wr is tied to 0.
//
//   state   | meaning
//   IDLE    | no further beats pending; output register accepts a new op
//   SEQ     | vector op in flight, beats_left > 0 beats still to load
module vector_ctrl_sequencer
   import vctrl_pkg::*;
#(
   parameter  int LANES  = 4,
   parameter  int VLMAX  = 16,
   localparam int VL_W   = $clog2(VLMAX + 1),
   localparam int BEAT_W = (VLMAX / LANES > 1) ? $clog2(VLMAX / LANES) : 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [6:0]        Op_i,
   input  logic [VL_W-1:0]   vl_i,
   output logic              valid_o,
   input  logic              ready_i,
   output ctrl_t             ctrl_o,
   output logic [BEAT_W-1:0] beat_o,
   output logic [LANES-1:0]  lane_mask_o,
   output logic              last_o
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SEQ  = 1'b1;

   logic [0:0]        state_q, state_d;
   logic              valid_q, valid_d;
   ctrl_t             ctrl_q, ctrl_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic [LANES-1:0]  mask_q, mask_d;
   logic              last_q, last_d;
   logic [BEAT_W-1:0] beats_left_q, beats_left_d;
   logic [VL_W-1:0]   vl_q, vl_d;

   ctrl_t             dec;
   logic [VL_W-1:0]   vl_clamp;
   logic [BEAT_W-1:0] gen_beat;
   logic [VL_W-1:0]   gen_vl;
   logic [LANES-1:0]  gen_mask;
   logic              gen_last;
   logic              out_free;
   int                n_beats;

   assign ready_o = (beats_left_q == '0) && (!valid_q || ready_i);
   assign out_free = !valid_q || ready_i;

   always_comb begin
      dec      = decode_op(Op_i);
      vl_clamp = (vl_i > VL_W'(VLMAX)) ? VL_W'(VLMAX) : vl_i;
      n_beats  = (vl_clamp == '0) ? 1 : (int'(vl_clamp) + LANES - 1) / LANES;
      gen_beat = (state_q == ST_SEQ) ? beat_q + BEAT_W'(1) : '0;
      gen_vl   = (state_q == ST_SEQ) ? vl_q : vl_clamp;
   end

   vctrl_lane_mask_gen #(
      .LANES  (LANES),
      .VL_W   (VL_W),
      .BEAT_W (BEAT_W)
   ) u_mask_gen (
      .beat_i      (gen_beat),
      .vl_i        (gen_vl),
      .lane_mask_o (gen_mask),
      .last_o      (gen_last)
   );

   always_comb begin
      state_d      = state_q;
      valid_d      = valid_q;
      ctrl_d       = ctrl_q;
      beat_d       = beat_q;
      mask_d       = mask_q;
      last_d       = last_q;
      beats_left_d = beats_left_q;
      vl_d         = vl_q;
      if (out_free) begin
         if (state_q == ST_SEQ) begin
            valid_d      = 1'b1;
            beat_d       = gen_beat;
            mask_d       = gen_mask;
            last_d       = gen_last;
            beats_left_d = beats_left_q - BEAT_W'(1);
         end else if (valid_i) begin
            valid_d = 1'b1;
            ctrl_d  = dec;
            beat_d  = '0;
            if (dec.vec) begin
               vl_d         = vl_clamp;
               mask_d       = gen_mask;
               last_d       = gen_last;
               beats_left_d = BEAT_W'(n_beats - 1);
               // an empty vector op must not write anything
               if (vl_clamp == '0) begin
                  ctrl_d.reg_write = 1'b0;
                  ctrl_d.mem_wr    = 1'b0;
                  ctrl_d.vmem_wr   = 1'b0;
               end
            end else begin
               mask_d       = '1;
               last_d       = 1'b1;
               beats_left_d = '0;
            end
         end else begin
            valid_d = 1'b0;
         end
      end
      state_d = (beats_left_d != '0) ? ST_SEQ : ST_IDLE;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         valid_q      <= 1'b0;
         ctrl_q       <= '0;
         beat_q       <= '0;
         mask_q       <= '0;
         last_q       <= 1'b0;
         beats_left_q <= '0;
         vl_q         <= '0;
      end else begin
         state_q      <= state_d;
         valid_q      <= valid_d;
         ctrl_q       <= ctrl_d;
         beat_q       <= beat_d;
         mask_q       <= mask_d;
         last_q       <= last_d;
         beats_left_q <= beats_left_d;
         vl_q         <= vl_d;
      end
   end

   always_comb begin
      ctrl_o = ctrl_q;
`ifndef VEC_MEM_EN
      ctrl_o.vmem_wr = 1'b0;
`endif
   end

   assign valid_o     = valid_q;
   assign beat_o      = beat_q;
   assign lane_mask_o = mask_q;
   assign last_o      = last_q;

endmodule
